// File: rtl/serial_subtractor_n_bit_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The requester drives start and operands; the subtractor drives status and results.
interface serial_subtractor_n_bit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, A, B, borrow_in,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, A, B, borrow_in,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor_n_bit.sv
// Bit-serial A - B - borrow_in, one bit per clock LSB first, around a 1-bit full subtractor cell.
// Results are published only on completion, so diff/borrow_out never show partial values.
module serial_subtractor_n_bit #(
  parameter int WIDTH = 8
) (
  input logic                     clk,
  input logic                     reset,
  serial_subtractor_n_bit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [RW-1:0]    res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             d_bit;
  logic             bo_bit;

  always_comb begin
    d_bit  = a_q[0] ^ b_q[0] ^ br_q;
    bo_bit = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  // res_q holds only the first WIDTH-1 difference bits; the final bit joins it on the last edge
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          br_d    = bus.borrow_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = RW'({d_bit, res_q} >> 1);
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = bo_bit;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = {d_bit, res_q};
          bout_d  = bo_bit;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bout_q;
endmodule

// File: tb/tb_serial_subtractor_n_bit.sv
// Bench for serial_subtractor_n_bit at WIDTH=8: directed cases plus random operands
// checked against a plain-arithmetic model of A - B - borrow_in.
module tb_serial_subtractor_n_bit;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor_n_bit_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor_n_bit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic void model(input int a, input int b, input int bin,
                                output logic [7:0] d, output logic bo);
    int r;
    r  = a - b - bin;
    d  = 8'(r);
    bo = (a < b + bin);
  endfunction

  // Issues one start, scrambles inputs while busy, and reports what the handshake did
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input int inject_at, output int busy_cycles, output int done_pulses,
                        output int done_at, output int partial_changes, output logic timed_out);
    logic [7:0] prev_diff;
    logic       prev_bo;
    @(negedge clk);
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.borrow_in = bin;
    prev_diff = bus.diff; prev_bo = bus.borrow_out;
    busy_cycles = 0; done_pulses = 0; done_at = 0; partial_changes = 0; timed_out = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        done_pulses++;
        if (done_at == 0) done_at = k;
      end
      if (!bus.done && done_pulses == 0 && (bus.diff !== prev_diff || bus.borrow_out !== prev_bo))
        partial_changes++;
      if (!bus.busy && k > 1) begin
        timed_out = 1'b0;
        break;
      end
      bus.A = 8'($urandom); bus.B = 8'($urandom); bus.borrow_in = 1'($urandom);
      bus.start = 1'b0;
      if (k == inject_at) begin
        bus.start = 1'b1; bus.A = 8'h00; bus.B = 8'hFF;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b0; bus.A = 8'h5A; bus.B = 8'h23; bus.borrow_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff: got %h expected 00", bus.diff); end
    n_checks++; if (bus.borrow_out !== 1'b0) begin n_fail++; $display("FAIL reset_borrow: got %b expected 0", bus.borrow_out); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 8'h00 || bus.borrow_out !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle_hold: got busy=%b done=%b diff=%h bo=%b expected 0/0/00/0",
                 bus.busy, bus.done, bus.diff, bus.borrow_out);
      end
    end
  endtask

  task automatic test_basic;
    int bc, dp, da, pc;
    logic to;
    run_op(8'h5A, 8'h23, 1'b0, 0, bc, dp, da, pc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b expected 0", to); end
    n_checks++; if (bc != WIDTH + 1) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, WIDTH + 1); end
    n_checks++; if (dp != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", dp); end
    n_checks++; if (da != WIDTH + 1) begin n_fail++; $display("FAIL basic_done_latency: got %0d expected %0d", da, WIDTH + 1); end
    n_checks++; if (pc != 0) begin n_fail++; $display("FAIL basic_partial: got %0d expected 0", pc); end
    n_checks++; if (bus.diff !== 8'h37) begin n_fail++; $display("FAIL basic_diff: got %h expected 37", bus.diff); end
    n_checks++; if (bus.borrow_out !== 1'b0) begin n_fail++; $display("FAIL basic_borrow: got %b expected 0", bus.borrow_out); end
    bus.A = 8'hC3; bus.B = 8'h99; bus.borrow_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.diff !== 8'h37 || bus.borrow_out !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: got diff=%h bo=%b busy=%b expected 37/0/0", bus.diff, bus.borrow_out, bus.busy);
    end
  endtask

  task automatic test_directed(input string name, input logic [7:0] va [2], input logic [7:0] vb [2],
                               input logic vbin [2], input logic [7:0] exp_d [2], input logic exp_bo [2]);
    int bc, dp, da, pc;
    logic to;
    for (int i = 0; i < 2; i++) begin
      run_op(va[i], vb[i], vbin[i], 0, bc, dp, da, pc, to);
      n_checks++;
      if (bus.diff !== exp_d[i]) begin
        n_fail++;
        $display("FAIL %s_diff[%0d]: got %h expected %h", name, i, bus.diff, exp_d[i]);
      end
      n_checks++;
      if (bus.borrow_out !== exp_bo[i] || dp != 1 || to !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_borrow[%0d]: got bo=%b pulses=%0d timeout=%b expected %b/1/0",
                 name, i, bus.borrow_out, dp, to, exp_bo[i]);
      end
    end
  endtask

  task automatic test_wrap_borrow;
    test_directed("wrap", '{8'h00, 8'hFF}, '{8'h01, 8'hFF}, '{1'b0, 1'b1}, '{8'hFF, 8'hFF}, '{1'b1, 1'b1});
  endtask

  task automatic test_borrow_in;
    test_directed("bin", '{8'h80, 8'h10}, '{8'h7F, 8'h00}, '{1'b1, 1'b1}, '{8'h00, 8'h0F}, '{1'b0, 1'b0});
  endtask

  task automatic test_busy_protect;
    int bc, dp, da, pc;
    logic to;
    run_op(8'h33, 8'h11, 1'b0, 3, bc, dp, da, pc, to);
    n_checks++; if (dp != 1) begin n_fail++; $display("FAIL protect_pulses: got %0d expected 1", dp); end
    n_checks++; if (bc != WIDTH + 1) begin n_fail++; $display("FAIL protect_busy_cycles: got %0d expected %0d", bc, WIDTH + 1); end
    n_checks++; if (bus.diff !== 8'h22) begin n_fail++; $display("FAIL protect_diff: got %h expected 22", bus.diff); end
    n_checks++; if (bus.borrow_out !== 1'b0) begin n_fail++; $display("FAIL protect_borrow: got %b expected 0", bus.borrow_out); end
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL protect_no_requeue: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid_op;
    int bc, dp, da, pc, late_done, late_busy;
    logic to;
    @(negedge clk);
    bus.start = 1'b1; bus.A = 8'h5A; bus.B = 8'h23; bus.borrow_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 8'h00 || bus.borrow_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%b done=%b diff=%h bo=%b expected 0/0/00/0",
               bus.busy, bus.done, bus.diff, bus.borrow_out);
    end
    late_done = 0; late_busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) late_done++;
      if (bus.busy) late_busy++;
    end
    n_checks++;
    if (late_done != 0 || late_busy != 0) begin
      n_fail++;
      $display("FAIL midreset_aborted: got done=%0d busy=%0d cycles expected 0/0", late_done, late_busy);
    end
    run_op(8'h01, 8'h02, 1'b0, 0, bc, dp, da, pc, to);
    n_checks++;
    if (bus.diff !== 8'hFF || bus.borrow_out !== 1'b1 || dp != 1) begin
      n_fail++;
      $display("FAIL midreset_rerun: got diff=%h bo=%b pulses=%0d expected FF/1/1", bus.diff, bus.borrow_out, dp);
    end
  endtask

  task automatic test_reset_start_same_edge;
    int seen_busy;
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b1; bus.A = 8'hAA; bus.B = 8'h11; bus.borrow_in = 1'b0;
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    seen_busy = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy || bus.done) seen_busy++;
      @(negedge clk);
    end
    n_checks++;
    if (seen_busy != 0 || bus.diff !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_start_tie: got active=%0d diff=%h expected 0/00", seen_busy, bus.diff);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp1, exp2, got1, got2;
    logic       ebo1, ebo2, gbo1, gbo2, idle_gap;
    int         dones, d_at1, d_at2;
    model(32'h12, 32'h34, 1, exp1, ebo1);
    model(32'hC8, 32'h45, 0, exp2, ebo2);
    @(negedge clk);
    bus.start = 1'b1; bus.A = 8'h12; bus.B = 8'h34; bus.borrow_in = 1'b1;
    dones = 0; d_at1 = 0; d_at2 = 0; idle_gap = 1'b0;
    got1 = 'x; got2 = 'x; gbo1 = 'x; gbo2 = 'x;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        if (dones == 1) begin d_at1 = k; got1 = bus.diff; gbo1 = bus.borrow_out; end
        if (dones == 2) begin d_at2 = k; got2 = bus.diff; gbo2 = bus.borrow_out; end
      end
      if (k == WIDTH + 2) idle_gap = ~bus.busy;
      if (k < WIDTH + 2) begin
        bus.A = 8'($urandom); bus.B = 8'($urandom); bus.borrow_in = 1'($urandom);
      end else if (k == WIDTH + 2) begin
        bus.A = 8'hC8; bus.B = 8'h45; bus.borrow_in = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
    end
    n_checks++;
    if (got1 !== exp1 || gbo1 !== ebo1) begin
      n_fail++; $display("FAIL b2b_first: got %h/%b expected %h/%b", got1, gbo1, exp1, ebo1);
    end
    n_checks++;
    if (got2 !== exp2 || gbo2 !== ebo2) begin
      n_fail++; $display("FAIL b2b_second: got %h/%b expected %h/%b", got2, gbo2, exp2, ebo2);
    end
    n_checks++;
    if (idle_gap !== 1'b1 || dones != 2 || d_at1 != WIDTH + 1 || d_at2 != 2 * WIDTH + 3) begin
      n_fail++;
      $display("FAIL b2b_timing: got gap=%b dones=%0d at %0d,%0d expected 1/2 at %0d,%0d",
               idle_gap, dones, d_at1, d_at2, WIDTH + 1, 2 * WIDTH + 3);
    end
  endtask

  task automatic test_random;
    int bc, dp, da, pc;
    logic to, bo_exp;
    logic [7:0] a, b, d_exp;
    logic bin;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      if (i == 0) begin a = 8'h00; b = 8'hFF; bin = 1'b1; end
      if (i == 1) begin a = 8'hFF; b = 8'h00; bin = 1'b0; end
      model(int'(a), int'(b), int'(bin), d_exp, bo_exp);
      run_op(a, b, bin, 0, bc, dp, da, pc, to);
      n_checks++;
      if (bus.diff !== d_exp || bus.borrow_out !== bo_exp) begin
        n_fail++;
        $display("FAIL rand_result[%0d] %h-%h-%b: got %h/%b expected %h/%b",
                 i, a, b, bin, bus.diff, bus.borrow_out, d_exp, bo_exp);
      end
      n_checks++;
      if (dp != 1 || da != WIDTH + 1 || bc != WIDTH + 1 || pc != 0 || to !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_handshake[%0d]: got pulses=%0d at=%0d busy=%0d partial=%0d timeout=%b expected 1/%0d/%0d/0/0",
                 i, dp, da, bc, pc, to, WIDTH + 1, WIDTH + 1);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.borrow_in = 1'b0;
    test_reset();
    test_basic();
    test_wrap_borrow();
    test_borrow_in();
    test_busy_protect();
    test_reset_mid_op();
    test_reset_start_same_edge();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
